// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller for the 8080 core: drives PC inc/load commands and the
// memory read strobe, and assembles 1..3 instruction bytes into one instruction word.
module fetch_sequencer #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk50M_i,
    input  logic        rst_ni,
    input  logic        fetch_en_i,
    output logic        mem_rd_o,
    input  logic        mem_ack_i,
    input  logic [7:0]  mem_dat_i,
    output logic        pc_load_o,
    output logic        pc_inc_o,
    output logic        pc_out_o,
    output logic [7:0]  pc_bus_o,
    output logic        pc_bus_en_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [7:0]  opcode_o,
    output logic [15:0] operand_o,
    output logic [1:0]  instr_len_o,
    input  logic        jump_i,
    input  logic [15:0] jump_addr_i,
    output logic        jump_done_o,
    output logic        fetch_err_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_INC, S_WAIT, S_VALID, S_JREQ, S_JLO, S_JHI
    } state_t;

    localparam logic [8:0] TMO_LIMIT = 9'(ACK_TIMEOUT);

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  tmo_q, tmo_d;
    logic [8:0]  tmo_next;
    logic [7:0]  opcode_q, opcode_d;
    logic [15:0] operand_q, operand_d;
    logic [1:0]  len_q, len_d;
    logic [15:0] jaddr_q, jaddr_d;
    logic        err_q, err_d;

    // Instruction length from the opcode; undefined opcodes follow the same bit rules.
    function automatic logic [1:0] decode_len(input logic [7:0] o);
        logic three, two;
        three = ((o[7:6] == 2'b00) && (o[3:0] == 4'b0001)) ||
                (o == 8'h22) || (o == 8'h2A) || (o == 8'h32) || (o == 8'h3A) ||
                (o == 8'hC3) || (o == 8'hCD) ||
                ((o[7:6] == 2'b11) && ((o[2:0] == 3'b010) || (o[2:0] == 3'b100)));
        two   = ((o[7:6] == 2'b00) && (o[2:0] == 3'b110)) ||
                ((o[7:6] == 2'b11) && (o[2:0] == 3'b110)) ||
                (o == 8'hD3) || (o == 8'hDB);
        if (three)    return 2'd3;
        else if (two) return 2'd2;
        else          return 2'd1;
    endfunction

    assign tmo_next = {1'b0, tmo_q} + 9'd1;

    always_ff @(posedge clk50M_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            idx_q     <= 2'd0;
            tmo_q     <= 8'd0;
            opcode_q  <= 8'd0;
            operand_q <= 16'd0;
            len_q     <= 2'd0;
            jaddr_q   <= 16'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            tmo_q     <= tmo_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
            len_q     <= len_d;
            jaddr_q   <= jaddr_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tmo_d     = tmo_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        len_d     = len_q;
        jaddr_d   = jaddr_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                if (jump_i) begin
                    jaddr_d = jump_addr_i;
                    state_d = S_JREQ;
                end else if (fetch_en_i) begin
                    idx_d     = 2'd0;
                    operand_d = 16'd0;
                    tmo_d     = 8'd0;
                    state_d   = S_RD;
                end
            end
            S_RD: begin
                tmo_d = tmo_next[7:0];
                if (mem_ack_i) begin
                    case (idx_q)
                        2'd0: begin
                            opcode_d = mem_dat_i;
                            len_d    = decode_len(mem_dat_i);
                        end
                        2'd1:    operand_d[7:0]  = mem_dat_i;
                        default: operand_d[15:8] = mem_dat_i;
                    endcase
                    state_d = S_INC;
                end else if (tmo_next == TMO_LIMIT) begin
                    // Abort without touching the PC; the flag stays until reset.
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_INC: state_d = S_WAIT;
            S_WAIT: begin
                if (({1'b0, idx_q} + 3'd1) < {1'b0, len_q}) begin
                    idx_d   = idx_q + 2'd1;
                    tmo_d   = 8'd0;
                    state_d = S_RD;
                end else begin
                    state_d = S_VALID;
                end
            end
            S_VALID: if (instr_ready_i) state_d = S_IDLE;
            S_JREQ:  state_d = S_JLO;
            S_JLO:   state_d = S_JHI;
            S_JHI:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // PC data port carries LSB during request/low phases, MSB in the final phase.
    always_comb begin
        pc_bus_o = 8'd0;
        if ((state_q == S_JREQ) || (state_q == S_JLO)) pc_bus_o = jaddr_q[7:0];
        else if (state_q == S_JHI)                      pc_bus_o = jaddr_q[15:8];
    end

    assign mem_rd_o      = (state_q == S_RD);
    assign pc_inc_o      = (state_q == S_INC);
    assign pc_load_o     = (state_q == S_JREQ);
    assign pc_out_o      = 1'b0;
    assign pc_bus_en_o   = (state_q == S_JREQ) || (state_q == S_JLO) || (state_q == S_JHI);
    assign jump_done_o   = (state_q == S_JHI);
    assign instr_valid_o = (state_q == S_VALID);
    assign opcode_o      = opcode_q;
    assign operand_o     = operand_q;
    assign instr_len_o   = len_q;
    assign fetch_err_o   = err_q;

endmodule
